spart_bus_arbiter: RTL and testbench

// Owns the SPART processor-side bus (iocs/iorw/ioaddr/databus). After reset, and on any br_cfg change,
// it programs the baud divisor (DB low, then DB high). It then shares the bus between two requesters

---
 rtl/spart_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_spart_bus_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/spart_bus_arbiter.sv
// SPART bus owner: programs the baud divisor after reset or a br_cfg change, then round-robins
// two requesters onto iocs/iorw/ioaddr/databus; request to ack is 2 cycles, TX/RX accesses gated on tbr/rda.
module spart_bus_arbiter #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] br_cfg,
   input  logic       req0,
   input  logic       rw0,
   input  logic [1:0] addr0,
   input  logic [7:0] wdata0,
   output logic       ack0,
   input  logic       req1,
   input  logic       rw1,
   input  logic [1:0] addr1,
   input  logic [7:0] wdata1,
   output logic       ack1,
   output logic [7:0] rdata,
   output logic       init_done,
   output logic       iocs,
   output logic       iorw,
   output logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   input  logic       rda,
   input  logic       tbr
);

   localparam int DIV_4800  = CLK_HZ / (16 * 4800)  - 1;
   localparam int DIV_9600  = CLK_HZ / (16 * 9600)  - 1;
   localparam int DIV_19200 = CLK_HZ / (16 * 19200) - 1;
   localparam int DIV_38400 = CLK_HZ / (16 * 38400) - 1;

   typedef enum logic [2:0] {INIT_LO, INIT_HI, IDLE, XFER, RESP} state_t;

   state_t     state, state_n;
   logic [1:0] br_cfg_q;
   logic       rr_last;
   logic       owner;
   logic       rw_q;
   logic [1:0] addr_q;
   logic [7:0] wdata_q;
   logic [7:0] rdata_q;
   logic [15:0] div;
   logic       elig0, elig1;
   logic       grant_vld, grant;
   logic       bus_on, bus_rw, bus_drv;
   logic [1:0] bus_addr;
   logic [7:0] bus_dout;

   always_comb begin
      case (br_cfg_q)
         2'b00:   div = 16'(DIV_4800);
         2'b01:   div = 16'(DIV_9600);
         2'b10:   div = 16'(DIV_19200);
         default: div = 16'(DIV_38400);
      endcase
   end

   // Buffer accesses wait for the SPART to be ready; other registers never block.
   assign elig0 = req0 && !(addr0 == 2'b00 && ((!rw0 && !tbr) || (rw0 && !rda)));
   assign elig1 = req1 && !(addr1 == 2'b00 && ((!rw1 && !tbr) || (rw1 && !rda)));

   always_comb begin
      state_n   = state;
      grant_vld = 1'b0;
      grant     = 1'b0;
      bus_on    = 1'b0;
      bus_rw    = 1'b0;
      bus_drv   = 1'b0;
      bus_addr  = 2'b00;
      bus_dout  = 8'h00;
      case (state)
         INIT_LO: begin
            bus_on   = 1'b1;
            bus_drv  = 1'b1;
            bus_addr = 2'b10;
            bus_dout = div[7:0];
            state_n  = INIT_HI;
         end
         INIT_HI: begin
            bus_on   = 1'b1;
            bus_drv  = 1'b1;
            bus_addr = 2'b11;
            bus_dout = div[15:8];
            state_n  = IDLE;
         end
         IDLE: begin
            if (br_cfg != br_cfg_q) begin
               state_n = INIT_LO;
            end else if (elig0 || elig1) begin
               grant_vld = 1'b1;
               grant     = elig1 && (!elig0 || !rr_last);
               state_n   = XFER;
            end
         end
         XFER: begin
            bus_on   = 1'b1;
            bus_rw   = rw_q;
            bus_drv  = !rw_q;
            bus_addr = addr_q;
            bus_dout = wdata_q;
            state_n  = RESP;
         end
         RESP:    state_n = IDLE;
         default: state_n = INIT_LO;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= INIT_LO;
         br_cfg_q <= br_cfg;
         rr_last  <= 1'b1;
         owner    <= 1'b0;
         rw_q     <= 1'b0;
         addr_q   <= 2'b00;
         wdata_q  <= 8'h00;
         rdata_q  <= 8'h00;
      end else begin
         state <= state_n;
         if (state == IDLE && br_cfg != br_cfg_q)
            br_cfg_q <= br_cfg;
         if (grant_vld) begin
            owner   <= grant;
            rr_last <= grant;
            rw_q    <= grant ? rw1 : rw0;
            addr_q  <= grant ? addr1 : addr0;
            wdata_q <= grant ? wdata1 : wdata0;
         end
         if (state == XFER && rw_q)
            rdata_q <= databus;
      end
   end

   // Bus outputs are gated by rst so an in-flight cycle is dropped without waiting for a clock.
   assign iocs      = bus_on && !rst;
   assign iorw      = bus_rw && !rst;
   assign ioaddr    = rst ? 2'b00 : bus_addr;
   assign databus   = (bus_drv && !rst) ? bus_dout : 8'bz;
   assign ack0      = (state == RESP) && !owner;
   assign ack1      = (state == RESP) && owner;
   assign rdata     = rdata_q;
   assign init_done = !(state == INIT_LO || state == INIT_HI);

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Directed bench for spart_bus_arbiter: a tiny SPART model answers reads on databus,
// and every expectation below is hand-computed from the divisor table and the arbitration rules.
module tb_spart_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] br_cfg;
   logic       req0, rw0, req1, rw1;
   logic [1:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       ack0, ack1;
   logic [7:0] rdata;
   logic       init_done;
   logic       iocs, iorw;
   logic [1:0] ioaddr;
   wire  [7:0] databus;
   logic       rda, tbr;
   logic       force_drv;
   logic [7:0] rx_byte;
   logic       tb_en;
   logic [7:0] tb_val;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // SPART side: answers reads; force_drv lets the bench prove the DUT has let go of the bus.
   assign tb_en   = force_drv || (iocs && iorw);
   assign tb_val  = force_drv ? 8'hA5 : ((ioaddr == 2'b00) ? rx_byte : {6'b0, rda, tbr});
   assign databus = tb_en ? tb_val : 8'bz;

   spart_bus_arbiter #(.CLK_HZ(50_000_000)) dut (
      .clk(clk), .rst(rst), .br_cfg(br_cfg),
      .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
      .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
      .rdata(rdata), .init_done(init_done),
      .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
      .rda(rda), .tbr(tbr)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Waits (bounded) for an ack and checks who got it, the read data and the cycle count.
   task automatic wait_ack(input string tag, input logic e0, input logic e1,
                           input logic [7:0] erd, input int ecyc);
      int  n    = 0;
      bit  seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         n++;
         if (ack0 || ack1) seen = 1'b1;
      end
      check({tag, "_seen"}, 16'(seen), 16'd1);
      check({tag, "_ack0"}, 16'(ack0), 16'(e0));
      check({tag, "_ack1"}, 16'(ack1), 16'(e1));
      check({tag, "_rdata"}, 16'(rdata), 16'(erd));
      check({tag, "_lat"}, 16'(n), 16'(ecyc));
      check({tag, "_iocs"}, 16'(iocs), 16'd0);
   endtask

   task automatic check_init(input string tag, input logic [7:0] lo, input logic [7:0] hi);
      check({tag, "_lo_cs"}, 16'({iocs, iorw, ioaddr}), 16'b1010);
      check({tag, "_lo_dat"}, 16'(databus), 16'(lo));
      check({tag, "_lo_done"}, 16'(init_done), 16'd0);
      @(negedge clk);
      check({tag, "_hi_cs"}, 16'({iocs, iorw, ioaddr}), 16'b1011);
      check({tag, "_hi_dat"}, 16'(databus), 16'(hi));
      check({tag, "_hi_done"}, 16'(init_done), 16'd0);
      @(negedge clk);
      check({tag, "_idle_cs"}, 16'(iocs), 16'd0);
      check({tag, "_done"}, 16'(init_done), 16'd1);
   endtask

   initial begin
      rst = 1'b1; br_cfg = 2'b01; force_drv = 1'b1; rx_byte = 8'h00;
      req0 = 0; rw0 = 0; addr0 = 0; wdata0 = 0;
      req1 = 0; rw1 = 0; addr1 = 0; wdata1 = 0;
      rda = 0; tbr = 1;
      repeat (2) @(negedge clk);
      check("rst_iocs", 16'(iocs), 16'd0);
      check("rst_iorw", 16'({iorw, ioaddr}), 16'd0);
      check("rst_ack", 16'({ack0, ack1}), 16'd0);
      check("rst_rdata", 16'(rdata), 16'd0);
      check("rst_done", 16'(init_done), 16'd0);
      check("rst_busz", 16'(databus), 16'hA5);

      rst = 1'b0; force_drv = 1'b0;
      #1;
      check_init("init9600", 8'h44, 8'h01);

      // Round robin from reset: requester 0 wins first tie, then alternation.
      req0 = 1; rw0 = 1; addr0 = 2'b01;
      req1 = 1; rw1 = 1; addr1 = 2'b01;
      wait_ack("rr_a0", 1, 0, 8'h01, 2);
      req0 = 0;
      wait_ack("rr_a1", 0, 1, 8'h01, 3);
      req0 = 1;
      wait_ack("rr_b0", 1, 0, 8'h01, 3);
      req0 = 0;
      wait_ack("rr_b1", 0, 1, 8'h01, 3);
      req1 = 0;
      @(negedge clk);

      // TX write held off by tbr=0, then issued one cycle after tbr rises.
      tbr = 0;
      req0 = 1; rw0 = 0; addr0 = 2'b00; wdata0 = 8'h41;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("tx_hold", 16'({iocs, ack0}), 16'd0);
      end
      tbr = 1;
      @(negedge clk);
      check("tx_cs", 16'({iocs, iorw, ioaddr}), 16'b1000);
      check("tx_dat", 16'(databus), 16'h41);
      check("tx_noack", 16'(ack0), 16'd0);
      @(negedge clk);
      check("tx_ack", 16'({ack0, ack1}), 16'b10);
      req0 = 0;
      @(negedge clk);

      // RX read blocked on rda must not block the status read of requester 1.
      rda = 0; rx_byte = 8'h5A;
      req0 = 1; rw0 = 1; addr0 = 2'b00;
      req1 = 1; rw1 = 1; addr1 = 2'b01;
      wait_ack("skip1", 0, 1, 8'h01, 2);
      req1 = 0; rda = 1;
      wait_ack("rx0", 1, 0, 8'h5A, 3);
      req0 = 0; rda = 0;
      @(negedge clk);

      // Baud change in IDLE beats a pending request, which is then served.
      br_cfg = 2'b11;
      req0 = 1; rw0 = 1; addr0 = 2'b01;
      @(negedge clk);
      check_init("init38400", 8'h50, 8'h00);
      check("br_noack", 16'(ack0), 16'd0);
      wait_ack("br_req", 1, 0, 8'h01, 2);
      req0 = 0;
      @(negedge clk);

      // Reset in the middle of a write releases the bus at once.
      req1 = 1; rw1 = 0; addr1 = 2'b00; wdata1 = 8'h3C;
      @(negedge clk);
      check("mid_cs", 16'(iocs), 16'd1);
      check("mid_dat", 16'(databus), 16'h3C);
      #1;
      rst = 1'b1; force_drv = 1'b1;
      #1;
      check("mid_rst_cs", 16'(iocs), 16'd0);
      check("mid_rst_busz", 16'(databus), 16'hA5);
      req1 = 0;
      @(negedge clk);
      check("mid_rst_ack", 16'({ack0, ack1}), 16'd0);
      check("mid_rst_done", 16'(init_done), 16'd0);
      rst = 1'b0; force_drv = 1'b0;
      #1;
      check_init("reinit", 8'h50, 8'h00);
      @(negedge clk);
      check("final_ack", 16'({ack0, ack1}), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1);
   end

endmodule
